// File: rtl/topk_pkg.sv
// Shared definitions for the top-K drain: default chain geometry, the
// boundary score held by empty stages, FSM encoding and width helpers.
package topk_pkg;

    localparam int DEF_TOP_K       = 30;
    localparam int DEF_DATA_WIDTH  = 4;
    localparam int DEF_INDEX_WIDTH = 9;

    // Score parked in every stage that has not received an element (-7).
    localparam logic signed [3:0] BOUNDARY = 4'sb1001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Width able to hold a result count from 0 to top_k inclusive.
    function automatic int n_width(input int top_k);
        return $clog2(top_k + 1);
    endfunction

    // Width of a rank (0 .. top_k-1); kept at least one bit wide.
    function automatic int rank_width(input int top_k);
        return (top_k > 1) ? $clog2(top_k) : 1;
    endfunction

endpackage

// File: rtl/topk_result_buf.sv
// Snapshot register file for the chain contents. All stages are written in
// the single capture cycle; the drain FSM reads one entry per rank.
module topk_result_buf
    import topk_pkg::*;
#(
    parameter int TOP_K       = DEF_TOP_K,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int RANK_W      = rank_width(TOP_K)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cap_en_i,
    input  logic [TOP_K*DATA_WIDTH-1:0]  pe_data_i,
    input  logic [TOP_K*INDEX_WIDTH-1:0] pe_index_i,
    input  logic [RANK_W-1:0]            rd_rank_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic [INDEX_WIDTH-1:0]       rd_index_o
);

    logic [DATA_WIDTH-1:0]  data_q  [TOP_K];
    logic [INDEX_WIDTH-1:0] index_q [TOP_K];

    // Capture every stage at once; empty entries start out at the boundary score.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TOP_K; k++) begin
                data_q[k]  <= DATA_WIDTH'(BOUNDARY);
                index_q[k] <= '0;
            end
        end else if (cap_en_i) begin
            for (int k = 0; k < TOP_K; k++) begin
                data_q[k]  <= pe_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                index_q[k] <= pe_index_i[k*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    // Rank-indexed read; ranks beyond the chain length read as zero.
    always_comb begin
        rd_data_o  = '0;
        rd_index_o = '0;
        if (int'(rd_rank_i) < TOP_K) begin
            rd_data_o  = data_q[rd_rank_i];
            rd_index_o = index_q[rd_rank_i];
        end
    end

endmodule

// File: rtl/topk_drain.sv
// Result reader for the systolic top-K sorter chain: waits for the chain to
// settle, snapshots it, clears it and streams the held results out in rank
// order on a valid/ready interface.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for i_start; N and flush counter load on the pulse
// FLUSH   | TOP_K cycles for the last element to ripple through the chain
// CAPTURE | snapshot all stages, pulse o_clear, reset rank
// SEND    | present buf[rank]; advance on o_valid & i_ready
// DONE    | one-cycle o_done, then back to IDLE
module topk_drain
    import topk_pkg::*;
#(
    parameter int TOP_K       = DEF_TOP_K,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int RANK_W      = rank_width(TOP_K)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [INDEX_WIDTH:0]         i_count,
    input  logic [TOP_K*DATA_WIDTH-1:0]  i_pe_data,
    input  logic [TOP_K*INDEX_WIDTH-1:0] i_pe_index,
    output logic                         o_clear,
    output logic                         o_busy,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [INDEX_WIDTH-1:0]       o_index,
    output logic [RANK_W-1:0]            o_rank,
    output logic                         o_last,
    output logic                         o_done
);

    localparam int NW = n_width(TOP_K);
    localparam int CW = INDEX_WIDTH + 1;

    state_t                   state_q;
    logic [NW-1:0]            n_q;
    logic [RANK_W-1:0]        flush_q;
    logic [RANK_W-1:0]        rank_q;
    logic                     clear_q;
    logic                     busy_q;
    logic                     valid_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic [RANK_W-1:0]        orank_q;
    logic                     last_q;
    logic                     done_q;

    logic [NW-1:0]            n_d;
    logic [RANK_W-1:0]        rank_d;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic [INDEX_WIDTH-1:0]   rd_index;

    // Result count is the stream length clipped to the chain depth.
    always_comb begin
        n_d    = (i_count >= CW'(TOP_K)) ? NW'(TOP_K) : NW'(i_count);
        rank_d = rank_q + RANK_W'(1);
    end

    // The mux looks one rank ahead so the next beat is ready to register
    // at the accepting edge.
    topk_result_buf #(
        .TOP_K       (TOP_K),
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .RANK_W      (RANK_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .cap_en_i   (state_q == ST_CAPTURE),
        .pe_data_i  (i_pe_data),
        .pe_index_i (i_pe_index),
        .rd_rank_i  (rank_d),
        .rd_data_o  (rd_data),
        .rd_index_o (rd_index)
    );

    // Drain sequencer with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            flush_q <= '0;
            rank_q  <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            orank_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        n_q     <= n_d;
                        flush_q <= RANK_W'(TOP_K - 1);
                        busy_q  <= 1'b1;
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == '0) begin
                        clear_q <= 1'b1;
                        state_q <= ST_CAPTURE;
                    end else begin
                        flush_q <= flush_q - RANK_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    rank_q <= '0;
                    if (n_q != '0) begin
                        // The buffer is being written this edge, so the
                        // first beat comes straight from stage 0.
                        valid_q <= 1'b1;
                        data_q  <= i_pe_data[DATA_WIDTH-1:0];
                        index_q <= i_pe_index[INDEX_WIDTH-1:0];
                        orank_q <= '0;
                        last_q  <= (n_q == NW'(1));
                        state_q <= ST_SEND;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_SEND: begin
                    if (i_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            index_q <= '0;
                            orank_q <= '0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rank_q  <= rank_d;
                            data_q  <= rd_data;
                            index_q <= rd_index;
                            orank_q <= rank_d;
                            last_q  <= (NW'(rank_d) == n_q - NW'(1));
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_clear = clear_q;
    assign o_busy  = busy_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_index = index_q;
    assign o_rank  = orank_q;
    assign o_last  = last_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_topk_drain.sv
// Self-checking bench for topk_drain with a 4-deep chain. Chain contents
// come from a stable top-K selection over random score streams.
module tb_topk_drain;

    localparam int K  = 4;
    localparam int DW = 4;
    localparam int IW = 9;
    localparam int RW = 2;
    localparam int FW = DW + IW + RW + 1;

    typedef struct {
        int d;
        int idx;
        int rank;
        int last;
        int cyc;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_start = 1'b0;
    logic [IW:0]     i_count = '0;
    logic [K*DW-1:0] pe_data = '0;
    logic [K*IW-1:0] pe_index = '0;
    logic            i_ready = 1'b1;
    logic            o_clear, o_busy, o_valid, o_last, o_done;
    logic [DW-1:0]   o_data;
    logic [IW-1:0]   o_index;
    logic [RW-1:0]   o_rank;

    int checks = 0;
    int failures = 0;

    int     exp_d [K];
    int     exp_i [K];
    beat_t  acc_q[$];
    int     clear_q[$];
    int     done_q[$];
    int     zero_viol, hold_viol, valid_cnt, post_rst_act;
    logic   busy_first, busy_after, timed_out;
    logic [FW+3:0] rst_obs;

    always #5 clk = ~clk;

    topk_drain #(.TOP_K(K), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_count(i_count),
        .i_pe_data(pe_data), .i_pe_index(pe_index),
        .o_clear(o_clear), .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_index(o_index), .o_rank(o_rank), .o_last(o_last),
        .o_done(o_done)
    );

    // Stable top-K of a stream: highest score first, earliest arrival on ties.
    task automatic load_stream(input int sc[$]);
        bit used [16];
        for (int i = 0; i < 16; i++) used[i] = 0;
        for (int r = 0; r < K; r++) begin
            int best = -1;
            for (int i = 0; i < sc.size(); i++)
                if (!used[i] && (best < 0 || sc[i] > sc[best])) best = i;
            if (best >= 0) begin
                used[best] = 1;
                exp_d[r] = sc[best];
                exp_i[r] = best;
            end else begin
                exp_d[r] = -7;
                exp_i[r] = 0;
            end
            pe_data[r*DW +: DW]  = DW'(exp_d[r]);
            pe_index[r*IW +: IW] = IW'(exp_i[r]);
        end
    endtask

    task automatic load_fixed();
        int d [K] = '{7, 5, 2, -3};
        int x [K] = '{12, 3, 40, 7};
        for (int r = 0; r < K; r++) begin
            exp_d[r] = d[r];
            exp_i[r] = x[r];
            pe_data[r*DW +: DW]  = DW'(d[r]);
            pe_index[r*IW +: IW] = IW'(x[r]);
        end
    endtask

    // Cycle (counted from the i_start edge) at which beat i is accepted.
    function automatic int beat_cyc(input int i, input int n, input int sr, input int sl);
        return K + 2 + i + ((sr < n && i >= sr) ? sl : 0);
    endfunction

    function automatic int min_n(input int count);
        return (count < K) ? count : K;
    endfunction

    // Pulse i_start, then watch the drain cycle by cycle, playing the ready pattern.
    task automatic run(input int count, input int sr, input int sl, input bit poke, input int rst_cyc);
        int stall_cnt = 0;
        int done_at = -1;
        bit prev_stall = 0;
        bit rdy;
        logic [FW-1:0] f, prev_f;
        prev_f = '0;
        acc_q.delete(); clear_q.delete(); done_q.delete();
        zero_viol = 0; hold_viol = 0; valid_cnt = 0; post_rst_act = 0;
        rst_obs = '1; busy_first = 0; busy_after = 1; timed_out = 1;
        @(posedge clk); #1;
        i_start = 1; i_count = (IW+1)'(count);
        @(posedge clk); #1;
        i_start = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            f = {o_data, o_index, o_rank, o_last};
            if (cyc == 1) busy_first = o_busy;
            if (o_clear) clear_q.push_back(cyc);
            if (o_done) begin
                done_q.push_back(cyc);
                done_at = cyc;
            end
            if (o_valid) valid_cnt++;
            else if (f != '0) zero_viol++;
            if (prev_stall && (!o_valid || f !== prev_f)) hold_viol++;
            if (rst_cyc != 0 && cyc == rst_cyc + 1) rst_obs = {o_clear, o_busy, o_valid, f, o_done};
            if (rst_cyc != 0 && cyc > rst_cyc + 1 && (o_busy | o_valid | o_done | o_clear)) post_rst_act++;
            rdy = 1;
            if (o_valid && int'(o_rank) == sr && stall_cnt < sl) begin
                rdy = 0;
                stall_cnt++;
            end
            if (o_valid && rdy && cyc != rst_cyc)
                acc_q.push_back('{int'($signed(o_data)), int'(o_index), int'(o_rank), int'(o_last), cyc});
            prev_stall = o_valid && !rdy;
            prev_f = f;
            i_ready = rdy;
            i_start = poke && (cyc == 2 || cyc == 7);
            if (poke) i_count = 1;
            rst = (rst_cyc != 0 && cyc == rst_cyc);
            if (done_at > 0 && cyc == done_at + 1) begin
                busy_after = o_busy;
                timed_out = 0;
                break;
            end
            if (rst_cyc != 0 && cyc == rst_cyc + 5) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        i_start = 0; i_ready = 1; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_clear, o_busy, o_valid, o_data, o_index, o_rank, o_last, o_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {o_clear, o_busy, o_valid, o_data, o_index, o_rank, o_last, o_done});
        end
        rst = 0;
    endtask

    task automatic test_full_drain();
        load_fixed();
        run(10, 9, 0, 0, 0);
        checks++;
        if (timed_out !== 1'b0) begin failures++; $display("FAIL full_timeout no o_done within bound"); end
        checks++;
        if (clear_q.size() != 1 || clear_q[0] != K + 1) begin
            failures++; $display("FAIL full_clear got_n=%0d first=%0d exp=%0d", clear_q.size(),
                                 clear_q.size() ? clear_q[0] : -1, K + 1);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_after !== 1'b0) begin
            failures++; $display("FAIL full_busy got first=%b after=%b exp 1/0", busy_first, busy_after);
        end
        checks++;
        if (acc_q.size() != K) begin failures++; $display("FAIL full_nbeats got=%0d exp=%0d", acc_q.size(), K); end
        for (int i = 0; i < acc_q.size() && i < K; i++) begin
            checks++;
            if (acc_q[i].d != exp_d[i] || acc_q[i].idx != exp_i[i] || acc_q[i].rank != i ||
                acc_q[i].last != (i == K - 1) || acc_q[i].cyc != K + 2 + i) begin
                failures++;
                $display("FAIL full_beat%0d got d=%0d i=%0d r=%0d l=%0d c=%0d exp d=%0d i=%0d r=%0d l=%0d c=%0d",
                         i, acc_q[i].d, acc_q[i].idx, acc_q[i].rank, acc_q[i].last, acc_q[i].cyc,
                         exp_d[i], exp_i[i], i, int'(i == K - 1), K + 2 + i);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 2 * K + 2) begin
            failures++; $display("FAIL full_done got_n=%0d first=%0d exp=%0d", done_q.size(),
                                 done_q.size() ? done_q[0] : -1, 2 * K + 2);
        end
        checks++;
        if (zero_viol != 0) begin failures++; $display("FAIL full_zero_idle got=%0d exp=0", zero_viol); end
    endtask

    task automatic test_short_stream();
        load_stream('{7, 5});
        run(2, 9, 0, 0, 0);
        checks++;
        if (acc_q.size() != 2) begin failures++; $display("FAIL short_nbeats got=%0d exp=2", acc_q.size()); end
        for (int i = 0; i < acc_q.size() && i < 2; i++) begin
            checks++;
            if (acc_q[i].d != exp_d[i] || acc_q[i].idx != exp_i[i] || acc_q[i].last != (i == 1)) begin
                failures++;
                $display("FAIL short_beat%0d got d=%0d i=%0d l=%0d exp d=%0d i=%0d l=%0d",
                         i, acc_q[i].d, acc_q[i].idx, acc_q[i].last, exp_d[i], exp_i[i], int'(i == 1));
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != K + 4) begin
            failures++; $display("FAIL short_done got_n=%0d first=%0d exp=%0d", done_q.size(),
                                 done_q.size() ? done_q[0] : -1, K + 4);
        end
    endtask

    task automatic test_empty_stream();
        load_fixed();
        run(0, 9, 0, 0, 0);
        checks++;
        if (valid_cnt != 0) begin failures++; $display("FAIL empty_valid got=%0d exp=0", valid_cnt); end
        checks++;
        if (clear_q.size() != 1 || clear_q[0] != K + 1) begin
            failures++; $display("FAIL empty_clear got_n=%0d exp_at=%0d", clear_q.size(), K + 1);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != K + 2) begin
            failures++; $display("FAIL empty_done got_n=%0d first=%0d exp=%0d", done_q.size(),
                                 done_q.size() ? done_q[0] : -1, K + 2);
        end
    endtask

    task automatic test_backpressure();
        load_fixed();
        run(10, 1, 3, 0, 0);
        checks++;
        if (hold_viol != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
        checks++;
        if (acc_q.size() != K) begin failures++; $display("FAIL bp_nbeats got=%0d exp=%0d", acc_q.size(), K); end
        for (int i = 0; i < acc_q.size() && i < K; i++) begin
            checks++;
            if (acc_q[i].d != exp_d[i] || acc_q[i].idx != exp_i[i] || acc_q[i].rank != i ||
                acc_q[i].cyc != beat_cyc(i, K, 1, 3)) begin
                failures++;
                $display("FAIL bp_beat%0d got d=%0d i=%0d r=%0d c=%0d exp d=%0d i=%0d r=%0d c=%0d",
                         i, acc_q[i].d, acc_q[i].idx, acc_q[i].rank, acc_q[i].cyc,
                         exp_d[i], exp_i[i], i, beat_cyc(i, K, 1, 3));
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 2 * K + 5) begin
            failures++; $display("FAIL bp_done got_n=%0d first=%0d exp=%0d", done_q.size(),
                                 done_q.size() ? done_q[0] : -1, 2 * K + 5);
        end
    endtask

    task automatic test_busy_restart();
        load_fixed();
        run(10, 9, 0, 1, 0);
        checks++;
        if (acc_q.size() != K || done_q.size() != 1 || done_q[0] != 2 * K + 2 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start got beats=%0d dones=%0d busy_after=%b exp beats=%0d dones=1 busy_after=0",
                     acc_q.size(), done_q.size(), busy_after, K);
        end
        run(10, 9, 0, 0, 7);
        checks++;
        if (rst_obs !== '0) begin failures++; $display("FAIL rst_mid_outputs got=%h exp=0", rst_obs); end
        checks++;
        if (done_q.size() != 0 || post_rst_act != 0) begin
            failures++; $display("FAIL rst_mid_quiet got dones=%0d activity=%0d exp 0/0", done_q.size(), post_rst_act);
        end
        run(3, 9, 0, 0, 0);
        checks++;
        if (acc_q.size() != 3 || done_q.size() != 1 || done_q[0] != K + 5 ||
            (acc_q.size() > 0 && (acc_q[0].d != exp_d[0] || acc_q[0].idx != exp_i[0]))) begin
            failures++;
            $display("FAIL rst_restart got beats=%0d dones=%0d exp beats=3 dones=1 at %0d", acc_q.size(), done_q.size(), K + 5);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int sc[$];
            int len = $urandom_range(0, 9);
            int cnt, n, sr, sl;
            for (int i = 0; i < len; i++) sc.push_back(int'($urandom_range(0, 13)) - 6);
            load_stream(sc);
            cnt = (len >= K && $urandom_range(0, 2) == 0) ? 1023 : len;
            n   = min_n(cnt);
            sr  = $urandom_range(0, K - 1);
            sl  = $urandom_range(0, 3);
            run(cnt, sr, sl, 0, 0);
            checks++;
            if (acc_q.size() != n || hold_viol != 0 || zero_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_stream got beats=%0d hold=%0d zero=%0d exp beats=%0d hold=0 zero=0",
                         it, acc_q.size(), hold_viol, zero_viol, n);
            end
            for (int i = 0; i < acc_q.size() && i < n; i++) begin
                checks++;
                if (acc_q[i].d != exp_d[i] || acc_q[i].idx != exp_i[i] || acc_q[i].rank != i ||
                    acc_q[i].last != (i == n - 1) || acc_q[i].cyc != beat_cyc(i, n, sr, sl)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got d=%0d i=%0d r=%0d l=%0d c=%0d exp d=%0d i=%0d r=%0d l=%0d c=%0d",
                             it, i, acc_q[i].d, acc_q[i].idx, acc_q[i].rank, acc_q[i].last, acc_q[i].cyc,
                             exp_d[i], exp_i[i], i, int'(i == n - 1), beat_cyc(i, n, sr, sl));
                end
            end
            checks++;
            if (done_q.size() != 1 ||
                done_q[0] != ((n == 0) ? K + 2 : beat_cyc(n - 1, n, sr, sl) + 1)) begin
                failures++;
                $display("FAIL rand%0d_done got_n=%0d first=%0d exp=%0d", it, done_q.size(),
                         done_q.size() ? done_q[0] : -1,
                         (n == 0) ? K + 2 : beat_cyc(n - 1, n, sr, sl) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_drain();
        test_short_stream();
        test_empty_stream();
        test_backpressure();
        test_busy_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
